// File: rtl/fetch_controller.sv
// Fetch/execute sequencer: issues one instruction fetch, hands the word to decode,
// waits for execute, then strobes the PC (increment or branch load) and counts retires.
module fetch_controller #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              fc_clk,
   input  logic              fc_rst_n,
   input  logic              fc_start,
   input  logic              fc_halt,
   output logic              fc_imem_req,
   input  logic              fc_imem_ack,
   input  logic [DATA_W-1:0] fc_imem_data,
   output logic [DATA_W-1:0] fc_instr,
   output logic              fc_instr_valid,
   input  logic              fc_exec_done,
   input  logic              fc_branch_taken,
   input  logic [DATA_W-1:0] fc_branch_target,
   output logic              fc_pc_cnt,
   output logic              fc_pc_wr_en,
   output logic              fc_pc_dir,
   output logic [DATA_W-1:0] fc_pc_load,
   output logic [DATA_W-1:0] fc_retired,
   output logic              fc_busy,
   output logic              fc_fault
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_EXEC, S_UPDATE, S_HALTED, S_FAULT
   } state_t;

   state_t              state_reg, state_next;
   logic [WAIT_W-1:0]   wait_reg, wait_next;
   logic                halt_pend_reg, halt_pend_next;
   logic                halt_seen;
   logic [DATA_W-1:0]   instr_reg, instr_next;
   logic [DATA_W-1:0]   load_reg, load_next;
   logic [DATA_W-1:0]   retired_reg, retired_next;
   logic                req_reg, req_next;
   logic                valid_reg, valid_next;
   logic                cnt_reg, cnt_next;
   logic                wr_reg, wr_next;
   logic                busy_reg, busy_next;
   logic                fault_reg, fault_next;

   always_comb begin
      state_next   = state_reg;
      wait_next    = wait_reg;
      instr_next   = instr_reg;
      load_next    = load_reg;
      retired_next = retired_reg;
      cnt_next     = 1'b0;
      wr_next      = 1'b0;

      case (state_reg)
         S_IDLE, S_HALTED: begin
            if (fc_start) state_next = S_FETCH;
         end
         S_FETCH: begin
            // An ack in the last permitted cycle still wins over the timeout.
            if (fc_imem_ack) begin
               instr_next = fc_imem_data;
               state_next = S_EXEC;
            end else if (wait_reg == WAIT_W'(TIMEOUT - 1)) begin
               state_next = S_FAULT;
            end else begin
               wait_next = wait_reg + WAIT_W'(1);
            end
         end
         S_EXEC: begin
            if (fc_exec_done) begin
               if (fc_branch_taken && (fc_branch_target[1:0] != 2'b00)) begin
                  state_next = S_FAULT;
               end else begin
                  state_next   = S_UPDATE;
                  retired_next = retired_reg + DATA_W'(1);
                  if (fc_branch_taken) begin
                     wr_next   = 1'b1;
                     load_next = fc_branch_target;
                  end else begin
                     cnt_next = 1'b1;
                  end
               end
            end
         end
         S_UPDATE: begin
            state_next = (halt_pend_reg || fc_halt) ? S_HALTED : S_FETCH;
         end
         S_FAULT: begin
            state_next = S_FAULT;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      if ((state_next == S_FETCH) && (state_reg != S_FETCH)) wait_next = '0;
   end

   // A halt arriving together with start still lets that one instruction run.
   always_comb begin
      halt_seen = 1'b0;
      if (fc_halt) begin
         if ((state_reg == S_FETCH) || (state_reg == S_EXEC) || (state_reg == S_UPDATE))
            halt_seen = 1'b1;
         else if (((state_reg == S_IDLE) || (state_reg == S_HALTED)) && fc_start)
            halt_seen = 1'b1;
      end
      halt_pend_next = (state_next == S_HALTED) ? 1'b0 : (halt_pend_reg | halt_seen);
   end

   always_comb begin
      req_next   = (state_next == S_FETCH);
      valid_next = (state_next == S_EXEC) && (state_reg == S_FETCH);
      busy_next  = (state_next == S_FETCH) || (state_next == S_EXEC) ||
                   (state_next == S_UPDATE);
      fault_next = (state_next == S_FAULT);
   end

   always_ff @(posedge fc_clk or negedge fc_rst_n) begin
      if (!fc_rst_n) begin
         state_reg     <= S_IDLE;
         wait_reg      <= '0;
         halt_pend_reg <= 1'b0;
         instr_reg     <= '0;
         load_reg      <= '0;
         retired_reg   <= '0;
         req_reg       <= 1'b0;
         valid_reg     <= 1'b0;
         cnt_reg       <= 1'b0;
         wr_reg        <= 1'b0;
         busy_reg      <= 1'b0;
         fault_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         wait_reg      <= wait_next;
         halt_pend_reg <= halt_pend_next;
         instr_reg     <= instr_next;
         load_reg      <= load_next;
         retired_reg   <= retired_next;
         req_reg       <= req_next;
         valid_reg     <= valid_next;
         cnt_reg       <= cnt_next;
         wr_reg        <= wr_next;
         busy_reg      <= busy_next;
         fault_reg     <= fault_next;
      end
   end

   assign fc_imem_req    = req_reg;
   assign fc_instr       = instr_reg;
   assign fc_instr_valid = valid_reg;
   assign fc_pc_cnt      = cnt_reg;
   assign fc_pc_wr_en    = wr_reg;
   assign fc_pc_dir      = 1'b0;
   assign fc_pc_load     = load_reg;
   assign fc_retired     = retired_reg;
   assign fc_busy        = busy_reg;
   assign fc_fault       = fault_reg;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed scoreboard bench for fetch_controller: fetched words and PC strobes are
// queued when driven and compared when the controller presents them.
module tb_fetch_controller;

   logic        fc_clk = 1'b0;
   logic        fc_rst_n = 1'b0;
   logic        fc_start = 1'b0;
   logic        fc_halt = 1'b0;
   logic        fc_imem_req;
   logic        fc_imem_ack = 1'b0;
   logic [31:0] fc_imem_data = '0;
   logic [31:0] fc_instr;
   logic        fc_instr_valid;
   logic        fc_exec_done = 1'b0;
   logic        fc_branch_taken = 1'b0;
   logic [31:0] fc_branch_target = '0;
   logic        fc_pc_cnt;
   logic        fc_pc_wr_en;
   logic        fc_pc_dir;
   logic [31:0] fc_pc_load;
   logic [31:0] fc_retired;
   logic        fc_busy;
   logic        fc_fault;

   int          tests = 0;
   int          failed = 0;
   logic [31:0] exp_retired = '0;
   logic [31:0] instr_q[$];
   logic [33:0] strobe_q[$];   // {cnt, wr_en, load}

   fetch_controller #(.DATA_W(32), .TIMEOUT(15)) dut (
      .fc_clk(fc_clk), .fc_rst_n(fc_rst_n), .fc_start(fc_start), .fc_halt(fc_halt),
      .fc_imem_req(fc_imem_req), .fc_imem_ack(fc_imem_ack), .fc_imem_data(fc_imem_data),
      .fc_instr(fc_instr), .fc_instr_valid(fc_instr_valid), .fc_exec_done(fc_exec_done),
      .fc_branch_taken(fc_branch_taken), .fc_branch_target(fc_branch_target),
      .fc_pc_cnt(fc_pc_cnt), .fc_pc_wr_en(fc_pc_wr_en), .fc_pc_dir(fc_pc_dir),
      .fc_pc_load(fc_pc_load), .fc_retired(fc_retired), .fc_busy(fc_busy),
      .fc_fault(fc_fault)
   );

   always #5 fc_clk = ~fc_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge fc_clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_instr"}, fc_instr, 32'h0);
      chk({tag, "_retired"}, fc_retired, 32'h0);
      chk({tag, "_load"}, fc_pc_load, 32'h0);
      chk({tag, "_strobes"}, {28'h0, fc_imem_req, fc_instr_valid, fc_pc_cnt, fc_pc_wr_en}, 32'h0);
      chk({tag, "_busy_fault"}, {30'h0, fc_busy, fc_fault}, 32'h0);
   endtask

   task automatic do_start();
      fc_start = 1'b1;
      tick();
      fc_start = 1'b0;
   endtask

   // Called at a negedge while the controller sits in FETCH cycle 1.
   task automatic run_instr(input logic [31:0] data, input int ack_dly, input int exec_dly,
                            input bit taken, input logic [31:0] tgt, input bit halt);
      logic [33:0] s;
      logic [31:0] w;
      for (int i = 0; i < ack_dly; i++) begin
         chk("req_wait", {31'h0, fc_imem_req}, 32'h1);
         tick();
      end
      chk("req", {31'h0, fc_imem_req}, 32'h1);
      fc_imem_data = data;
      fc_imem_ack  = 1'b1;
      instr_q.push_back(data);
      tick();
      fc_imem_ack  = 1'b0;
      fc_imem_data = ~data;
      w = instr_q.pop_front();
      chk("instr_valid", {31'h0, fc_instr_valid}, 32'h1);
      chk("instr", fc_instr, w);
      chk("req_exec", {31'h0, fc_imem_req}, 32'h0);
      if (halt) fc_halt = 1'b1;
      for (int i = 0; i < exec_dly; i++) begin
         tick();
         fc_halt = 1'b0;
         chk("instr_valid_low", {31'h0, fc_instr_valid}, 32'h0);
         chk("instr_stable", fc_instr, w);
      end
      fc_exec_done     = 1'b1;
      fc_branch_taken  = taken;
      fc_branch_target = tgt;
      strobe_q.push_back(taken ? {2'b01, tgt} : {2'b10, 32'h0});
      exp_retired = exp_retired + 32'h1;
      tick();
      fc_exec_done    = 1'b0;
      fc_branch_taken = 1'b0;
      fc_halt         = 1'b0;
      s = strobe_q.pop_front();
      chk("pc_cnt", {31'h0, fc_pc_cnt}, {31'h0, s[33]});
      chk("pc_wr_en", {31'h0, fc_pc_wr_en}, {31'h0, s[32]});
      if (s[32]) chk("pc_load", fc_pc_load, s[31:0]);
      chk("retired", fc_retired, exp_retired);
      tick();
      chk("strobes_after_update", {30'h0, fc_pc_cnt, fc_pc_wr_en}, 32'h0);
      if (halt) chk("halted_busy_req", {30'h0, fc_busy, fc_imem_req}, 32'h0);
      else      chk("next_fetch", {30'h0, fc_busy, fc_imem_req}, 32'h3);
   endtask

   task automatic async_reset();
      #2 fc_rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      instr_q.delete();
      strobe_q.delete();
      exp_retired = '0;
      tick();
      fc_rst_n = 1'b1;
      tick();
   endtask

   initial begin
      // Power-on reset
      #1 chk_all_zero("por");
      chk("pc_dir", {31'h0, fc_pc_dir}, 32'h0);
      tick();
      fc_rst_n = 1'b1;
      tick();

      // Spurious ack / exec_done in IDLE
      fc_imem_ack = 1'b1; fc_imem_data = 32'hDEAD_BEEF; fc_exec_done = 1'b1;
      tick(); tick();
      fc_imem_ack = 1'b0; fc_exec_done = 1'b0;
      chk_all_zero("idle_spurious");

      // Four back-to-back sequential instructions
      do_start();
      for (int i = 0; i < 4; i++)
         run_instr(32'h1000_0000 + 32'(i), 0, 0, 1'b0, 32'h0, 1'b0);
      chk("retired_after_4", fc_retired, 32'd4);

      // Aligned taken branch
      run_instr(32'h2000_0001, 0, 1, 1'b1, 32'h0000_0100, 1'b0);

      // Ack in the final permitted FETCH cycle
      run_instr(32'h3000_0002, 14, 0, 1'b0, 32'h0, 1'b0);

      // Halt pulsed mid-EXEC
      run_instr(32'h4000_0003, 0, 2, 1'b0, 32'h0, 1'b1);
      tick();
      chk("halted_retired_kept", fc_retired, exp_retired);
      chk("halted_busy", {31'h0, fc_busy}, 32'h0);

      // Retire counter wrap
      force dut.retired_reg = 32'hFFFF_FFFF;
      tick();
      release dut.retired_reg;
      exp_retired = 32'hFFFF_FFFF;
      tick();
      chk("preload", fc_retired, exp_retired);
      do_start();
      chk("resume_req", {31'h0, fc_imem_req}, 32'h1);
      run_instr(32'h5000_0004, 0, 0, 1'b0, 32'h0, 1'b0);
      chk("wrap_zero", fc_retired, 32'h0);

      // Misaligned taken branch
      fc_imem_data = 32'h6000_0005; fc_imem_ack = 1'b1;
      tick();
      fc_imem_ack = 1'b0;
      chk("mis_instr", fc_instr, 32'h6000_0005);
      fc_exec_done = 1'b1; fc_branch_taken = 1'b1; fc_branch_target = 32'h0000_0102;
      tick();
      fc_exec_done = 1'b0; fc_branch_taken = 1'b0;
      chk("mis_fault", {31'h0, fc_fault}, 32'h1);
      chk("mis_strobes", {29'h0, fc_pc_cnt, fc_pc_wr_en, fc_busy}, 32'h0);
      chk("mis_retired", fc_retired, exp_retired);
      fc_start = 1'b1;
      tick(); tick();
      fc_start = 1'b0;
      chk("fault_sticky", {30'h0, fc_fault, fc_imem_req}, 32'h2);

      // Asynchronous reset while in EXEC
      async_reset();
      do_start();
      fc_imem_data = 32'h7000_0006; fc_imem_ack = 1'b1;
      tick();
      fc_imem_ack = 1'b0;
      chk("pre_rst_instr", fc_instr, 32'h7000_0006);
      tick();
      async_reset();

      // Fetch timeout
      do_start();
      for (int i = 1; i <= 15; i++) begin
         chk($sformatf("to_req_c%0d", i), {31'h0, fc_imem_req}, 32'h1);
         tick();
      end
      chk("to_fault", {31'h0, fc_fault}, 32'h1);
      chk("to_req_drop", {30'h0, fc_imem_req, fc_busy}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Multi-cycle fetch/execute sequencer that drives the program counter's control inputs (count, load, direction) and the instruction-memory request handshake. It sits between the 32-bit PC register, instruction memory and the execute stage. It issues one fetch per instruction, presents the latched instruction to decode, waits for execute completion, then commands either a +4 increment or a branch-target load. It also counts retired instructions and traps on memory timeouts and misaligned branch targets.

## Interface
- DATA_W, 32, width of PC, instruction, branch target and retire counter
- TIMEOUT, 15, max FETCH cycles waiting for fc_imem_ack before fault (≥1)

- fc_clk  in  1  clock, all state on rising edge
- fc_rst_n  in  1  reset, asynchronous, active-low
- fc_start  in  1  leave IDLE/HALTED and begin fetching
- fc_halt  in  1  halt request, honoured at next instruction boundary
- fc_imem_req  out  1  instruction-memory read request (address = PC register output)
- fc_imem_ack  in  1  read data valid
- fc_imem_data  in  DATA_W  instruction word
- fc_instr  out  DATA_W  latched instruction to decode
- fc_instr_valid  out  1  one-cycle pulse, fc_instr newly valid
- fc_exec_done  in  1  execute stage finished current instruction
- fc_branch_taken  in  1  sampled with fc_exec_done
- fc_branch_target  in  DATA_W  sampled with fc_exec_done
- fc_pc_cnt  out  1  PC increment strobe
- fc_pc_wr_en  out  1  PC load strobe
- fc_pc_dir  out  1  PC direction; constant 0 (up)
- fc_pc_load  out  DATA_W  PC load value
- fc_retired  out  DATA_W  retired-instruction count
- fc_busy  out  1  high in FETCH, EXEC, UPDATE
- fc_fault  out  1  sticky fault flag

## Operation
- States: IDLE, FETCH, EXEC, UPDATE, HALTED, FAULT. All outputs registered.
- IDLE: all strobes low; fc_start → FETCH.
- FETCH: fc_imem_req=1 held until ack. On ack: fc_instr ← fc_imem_data, → EXEC. Wait counter cleared on entry; ack accepted in FETCH cycles 1..TIMEOUT; no ack by end of cycle TIMEOUT → FAULT.
- EXEC: fc_instr_valid=1 in first EXEC cycle only. On fc_exec_done (any EXEC cycle, including the first):
  - taken, target[1:0]≠0 → FAULT (PC untouched, retire not counted)
  - taken, aligned → UPDATE with fc_pc_wr_en=1, fc_pc_load=target
  - not taken → UPDATE with fc_pc_cnt=1
  - fc_retired += 1 (mod 2^DATA_W, wraps 0xFFFFFFFF→0)
- UPDATE: exactly one cycle; exactly one of fc_pc_cnt/fc_pc_wr_en high. Then → HALTED if halt pending, else → FETCH.
- HALTED: strobes low, fc_busy=0; fc_start → FETCH. Retire count preserved.
- FAULT: fc_fault=1, all strobes low; exits only via reset.
- Halt pending: set by fc_halt in any state except IDLE/HALTED/FAULT; cleared on entering HALTED. Never aborts an in-flight fetch or execute.
- fc_start and fc_halt together in IDLE: start wins, one instruction executes, then HALTED.
- fc_imem_ack outside FETCH and fc_exec_done outside EXEC are ignored.
- fc_pc_wr_en and fc_pc_cnt are never high together.

## Timing
- Reset (async assert): state IDLE. All outputs 0: fc_instr, fc_pc_load and fc_retired are 0; fc_fault is 0. Halt pending and wait counter are cleared. This applies at any point mid-operation.
- Minimum instruction: 3 cycles (FETCH with same-cycle ack, EXEC with exec_done in its first cycle, UPDATE).
- fc_instr is stable from the first EXEC cycle until the next FETCH ack.
- The PC strobe in UPDATE takes effect at the end of UPDATE. The following FETCH sees the new PC.
- fc_fault rises in the cycle after the fault-triggering edge.

## Test plan
- Reset, start, ack on first FETCH cycle, exec_done in first EXEC cycle, 4 sequential instructions → fc_pc_cnt pulses every 3rd cycle, fc_retired=4, fc_pc_wr_en never high.
- Taken branch with target 0x0000_0100 → one-cycle fc_pc_wr_en with fc_pc_load=0x100, fc_pc_cnt low; taken with target 0x102 → fc_fault=1, no PC strobe, fc_retired unchanged.
- Ack withheld: TIMEOUT=15 with ack in FETCH cycle 15 → normal EXEC. Ack never arrives → FAULT after cycle 15, fc_imem_req drops.
- fc_halt pulsed mid-EXEC → current instruction retires, UPDATE strobe issued, then HALTED (fc_busy=0); fc_start → fetching resumes at the updated PC.
- fc_retired preloaded near wrap (run to 0xFFFF_FFFF via forced state) → next retire gives 0.
- fc_rst_n asserted in EXEC between clock edges → outputs 0 immediately. Spurious ack/exec_done while in IDLE is ignored.
